// File: rtl/accumulate_window_if.sv
// Sample-stream, adder-operand and result signals of accumulate_window, bundled with
// modports for the accumulator (slave) and its environment (master).
interface accumulate_window_if;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        sample_ready;

  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_cin;
  logic [15:0] add_sum;
  logic        add_overflow;

  logic        result_valid;
  logic [15:0] result_data;
  logic        result_overflow;
  logic        result_ack;

  modport slave (
    input  sample_valid,
    input  sample_data,
    output sample_ready,
    output add_a,
    output add_b,
    output add_cin,
    input  add_sum,
    input  add_overflow,
    output result_valid,
    output result_data,
    output result_overflow,
    input  result_ack
  );

  modport master (
    output sample_valid,
    output sample_data,
    input  sample_ready,
    input  add_a,
    input  add_b,
    input  add_cin,
    output add_sum,
    output add_overflow,
    input  result_valid,
    input  result_data,
    input  result_overflow,
    output result_ack
  );
endinterface

// File: rtl/accumulate_window.sv
// Windowed accumulator around an external 16-bit adder: sums NUM_SAMPLES accepted samples,
// tracks a sticky carry-out, and holds the result until acknowledged.
module accumulate_window #(
  parameter int unsigned NUM_SAMPLES = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  accumulate_window_if.slave  bus
);

  localparam int unsigned CntW = $clog2(NUM_SAMPLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_SAMPLES - 1);

  if (NUM_SAMPLES < 2 || NUM_SAMPLES > 256) begin : g_bad_param
    $error("accumulate_window: NUM_SAMPLES must be in 2..256");
  end

  typedef enum logic [0:0] {StAccum, StDone} state_e;

  state_e          state_q, state_d;
  logic [15:0]     acc_q, acc_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            xfer;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StAccum;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.sample_ready = (state_q == StAccum) && !clear;
  assign xfer             = bus.sample_valid && bus.sample_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    // clear overrides both a pending transfer and a concurrent result_ack
    if (clear) begin
      state_d = StAccum;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (xfer) begin
            acc_d = bus.add_sum;
            ovf_d = ovf_q | bus.add_overflow;
            if (count_q == LastCnt) begin
              count_d = '0;
              state_d = StDone;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
        StDone: begin
          if (bus.result_ack) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            state_d = StAccum;
          end
        end
        default: state_d = StAccum;
      endcase
    end
  end

  assign bus.add_a           = acc_q;
  assign bus.add_b           = bus.sample_data;
  assign bus.add_cin         = 1'b0;
  assign bus.result_valid    = (state_q == StDone);
  assign bus.result_data     = acc_q;
  assign bus.result_overflow = ovf_q;

endmodule

// File: tb/tb_accumulate_window.sv
// Directed bench for accumulate_window (NUM_SAMPLES = 4) with a behavioural 16-bit adder.
module tb_accumulate_window;

  logic clk;
  logic n_rst;
  logic clear;
  int   vectors;
  int   miscompares;

  accumulate_window_if bus ();

  accumulate_window #(
    .NUM_SAMPLES (4)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .bus   (bus)
  );

  assign {bus.add_overflow, bus.add_sum} =
    {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'h0000, bus.add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one sample, confirm it is accepted, and pass the capturing edge.
  task automatic push(input logic [15:0] d);
    bus.sample_valid = 1'b1;
    bus.sample_data  = d;
    #1;
    check("push_ready", bus.sample_ready, 1'b1);
    check("add_b_pass", bus.add_b, d);
    step();
  endtask

  task automatic ack();
    bus.result_ack = 1'b1;
    step();
    bus.result_ack = 1'b0;
    #1;
    check("ack_valid", bus.result_valid, 1'b0);
    check("ack_ready", bus.sample_ready, 1'b1);
    check("ack_acc",   bus.add_a, 16'h0000);
  endtask

  initial begin
    logic [6:0] gap_pat;
    vectors          = 0;
    miscompares      = 0;
    n_rst            = 1'b0;
    clear            = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_data  = 16'h0000;
    bus.result_ack   = 1'b0;

    // Reset state
    #12;
    check("rst_valid", bus.result_valid, 1'b0);
    check("rst_data",  bus.result_data, 16'h0000);
    check("rst_ovf",   bus.result_overflow, 1'b0);
    check("rst_add_a", bus.add_a, 16'h0000);
    check("rst_cin",   bus.add_cin, 1'b0);
    check("rst_ready", bus.sample_ready, 1'b1);
    n_rst = 1'b1;
    step();

    // Basic window
    push(16'h0001);
    check("b1_acc", bus.add_a, 16'h0001);
    push(16'h0002);
    check("b2_acc", bus.add_a, 16'h0003);
    push(16'h0003);
    check("b3_valid", bus.result_valid, 1'b0);
    push(16'h0004);
    bus.sample_valid = 1'b0;
    check("b_valid", bus.result_valid, 1'b1);
    check("b_data",  bus.result_data, 16'h000A);
    check("b_ovf",   bus.result_overflow, 1'b0);
    check("b_ready", bus.sample_ready, 1'b0);
    ack();

    // Sticky overflow: only the second add carries
    push(16'hFFFF);
    check("o1_ovf", bus.result_overflow, 1'b0);
    push(16'h0002);
    check("o2_acc", bus.add_a, 16'h0001);
    push(16'h0000);
    push(16'h0000);
    bus.sample_valid = 1'b0;
    check("o_valid", bus.result_valid, 1'b1);
    check("o_data",  bus.result_data, 16'h0001);
    check("o_ovf",   bus.result_overflow, 1'b1);
    ack();
    check("o_ovf_cleared", bus.result_overflow, 1'b0);

    // Backpressure: result held while valid stays high and ack is low
    push(16'h0005);
    push(16'h0006);
    push(16'h0007);
    push(16'h0008);
    bus.sample_data = 16'h0099;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_ready", bus.sample_ready, 1'b0);
      check("bp_valid", bus.result_valid, 1'b1);
      check("bp_data",  bus.result_data, 16'h001A);
      step();
    end
    bus.result_ack = 1'b1;
    step();
    bus.result_ack   = 1'b0;
    bus.sample_valid = 1'b0;
    #1;
    check("bp_ready_after", bus.sample_ready, 1'b1);
    check("bp_acc_zero",    bus.add_a, 16'h0000);
    check("bp_valid_after", bus.result_valid, 1'b0);

    // Gapped input
    gap_pat = 7'b1101001;  // bit i is valid in cycle i: 1,0,0,1,0,1,1
    for (int i = 0; i < 7; i++) begin
      bus.sample_valid = gap_pat[i];
      bus.sample_data  = 16'h1000;
      step();
      check("gap_valid", bus.result_valid, (i == 6) ? 1'b1 : 1'b0);
    end
    bus.sample_valid = 1'b0;
    check("gap_data", bus.result_data, 16'h4000);
    check("gap_ovf",  bus.result_overflow, 1'b0);
    ack();

    // Clear mid-window drops the partial sum and the sample offered with it
    push(16'h0005);
    push(16'h0005);
    check("c_partial", bus.add_a, 16'h000A);
    bus.sample_valid = 1'b1;
    bus.sample_data  = 16'h0005;
    clear            = 1'b1;
    #1;
    check("c_ready", bus.sample_ready, 1'b0);
    step();
    clear            = 1'b0;
    bus.sample_valid = 1'b0;
    #1;
    check("c_acc",   bus.add_a, 16'h0000);
    check("c_valid", bus.result_valid, 1'b0);
    for (int i = 0; i < 4; i++) push(16'h0001);
    bus.sample_valid = 1'b0;
    check("c_res_valid", bus.result_valid, 1'b1);
    check("c_res_data",  bus.result_data, 16'h0004);

    // Clear together with ack in DONE
    clear          = 1'b1;
    bus.result_ack = 1'b1;
    step();
    clear          = 1'b0;
    bus.result_ack = 1'b0;
    #1;
    check("ca_valid", bus.result_valid, 1'b0);
    check("ca_acc",   bus.add_a, 16'h0000);
    check("ca_ready", bus.sample_ready, 1'b1);

    // Async reset in DONE takes effect between edges
    for (int i = 0; i < 4; i++) push(16'hFFFF);
    bus.sample_valid = 1'b0;
    check("r_valid_pre", bus.result_valid, 1'b1);
    check("r_data_pre",  bus.result_data, 16'hFFFC);
    check("r_ovf_pre",   bus.result_overflow, 1'b1);
    #3;
    n_rst = 1'b0;
    #1;
    check("r_valid", bus.result_valid, 1'b0);
    check("r_data",  bus.result_data, 16'h0000);
    check("r_ovf",   bus.result_overflow, 1'b0);
    check("r_add_a", bus.add_a, 16'h0000);
    #2;
    n_rst = 1'b1;
    step();
    for (int i = 0; i < 4; i++) push(16'h0003);
    bus.sample_valid = 1'b0;
    check("r_res_valid", bus.result_valid, 1'b1);
    check("r_res_data",  bus.result_data, 16'h000C);
    check("r_res_ovf",   bus.result_overflow, 1'b0);
    ack();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
